data_bus_controller: RTL and testbench
======================================

Name: data_bus_controller

Overview:
Sits downstream of the pipeline's EX/MEM stage and replaces the single-cycle data RAM port with a request/acknowledge bus to a variable-latency external data memory. It takes the MEM-stage memory operation, address and store data, and runs one bus transaction per load or store. It stalls the whole pipeline until the transaction completes, then presents load data to the MEM/WB register. A watchdog aborts transactions that are never acknowledged.

Parameters:
TIMEOUT_CYCLES, 255, max WAIT cycles before abort; 0 disables the watchdog
ERROR_DATA, 16'hFFFF, value returned on cpu_read_data for a timed-out load

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cpu_mem_op  input  2  MEM-stage op: 00 none, 01 load, 10 store, 11 reserved (treated as none)
cpu_address  input  16  MEM-stage address (after address-source mux)
cpu_write_data  input  16  store data
cpu_read_data  output  16  load result, registered
cpu_stall  output  1  freeze all pipeline registers and PC while high
bus_req  output  1  transaction request, registered
bus_we  output  1  1 = write, valid while bus_req
bus_addr  output  16  latched address, valid while bus_req
bus_wdata  output  16  latched store data, valid while bus_req
bus_ack  input  1  one-cycle completion strobe from memory
bus_rdata  input  16  read data, sampled only in the cycle bus_ack is high
bus_error  output  1  sticky timeout flag
error_clear  input  1  clears bus_error

Behaviour:
- Reset (async, any state): state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_read_data=0, bus_error=0, watchdog count=0. cpu_stall is 0 in reset. Any in-flight transaction is abandoned.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If cpu_mem_op is 01 or 10, cpu_stall=1 combinationally in the same cycle.
  - On that clock edge: latch address, data and we=(op==10); set bus_req=1; clear the count; go to WAIT.
  - Otherwise stay in IDLE with cpu_stall=0.
- WAIT:
  - cpu_stall=1 and bus_req=1; address, data and we held stable.
  - On bus_ack: bus_req drops at the next edge; go to DONE.
    - For a load, cpu_read_data<=bus_rdata on that edge.
    - For a store, cpu_read_data is unchanged.
  - Without ack: count increments each cycle. When TIMEOUT_CYCLES != 0 and count reaches TIMEOUT_CYCLES-1 with no ack:
    - bus_req<=0 and bus_error<=1.
    - For a load, cpu_read_data<=ERROR_DATA.
    - Go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and bus_error is not set.
- DONE:
  - cpu_stall=0 for exactly one cycle, so the pipeline advances and MEM/WB captures cpu_read_data.
  - No new transaction starts in DONE, even though cpu_mem_op still shows the completed op.
  - Return to IDLE on the next edge.
- bus_ack in IDLE or DONE is ignored; cpu_read_data is not modified.
- Latency: a load with ack arriving N cycles after bus_req rises holds cpu_stall high for N+2 cycles (IDLE detect, N WAIT, ack cycle). Minimum N=0, meaning ack in the first WAIT cycle, gives 2 stall cycles.
- Back-to-back memory ops: IDLE, WAIT, DONE, IDLE, WAIT; there is always one non-stalled DONE cycle between transactions.
- bus_error: set on timeout and held until error_clear=1. error_clear is synchronous. If timeout and error_clear occur in the same cycle, set wins.
- Watchdog width: $clog2(TIMEOUT_CYCLES+1) bits, saturating, never wraps.

Decomposition:
- Shared package:
  - mem_op encodings: MEM_OP_NONE=2'b00, MEM_OP_LOAD=2'b01, MEM_OP_STORE=2'b10.
  - State enum: IDLE, WAIT, DONE.
  - Default ERROR_DATA constant.
- Sub-module bus_timeout_counter:
  - Parameterised saturating counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Reused later by the instruction-fetch bus.

Test Plan:
- Load addr 16'h0010, memory acks 3 cycles after bus_req with rdata 16'hBEEF -> bus_req high 4 cycles, bus_we=0, bus_addr=16'h0010; cpu_stall high 5 cycles; cpu_read_data=16'hBEEF in DONE; stall low 1 cycle.
- Store addr 16'h0020 data 16'h1234, ack in first WAIT cycle -> bus_we=1, bus_wdata=16'h1234, stall 2 cycles, cpu_read_data unchanged.
- Load with no ack, TIMEOUT_CYCLES=8 -> bus_req drops after 8 WAIT cycles; bus_error=1; cpu_read_data=16'hFFFF; bus_error stays 1 until a pulse on error_clear.
- Ack and timeout in the same cycle (TIMEOUT_CYCLES=4, ack on 4th WAIT cycle, rdata 16'h00A5) -> cpu_read_data=16'h00A5, bus_error=0.
- Store then load back-to-back (ops held by the stalled pipeline) -> exactly one DONE cycle with stall low between them; the second bus_req rises two cycles after the first ack.
- Assert reset during WAIT of a load -> bus_req, cpu_stall, bus_error and cpu_read_data all 0 immediately; a later ack is ignored; the next load runs normally.

Source files
------------

// File: rtl/data_bus_controller_pkg.sv
// rtl/data_bus_controller_pkg.sv - shared encodings and defaults for the data bus controller
package data_bus_controller_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [15:0] DEFAULT_ERROR_DATA = 16'hFFFF;

    // Reserved encoding behaves as no operation.
    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
    endfunction

endpackage

// File: rtl/data_bus_controller_if.sv
// rtl/data_bus_controller_if.sv - request/acknowledge data memory bus
interface data_bus_controller_if;

    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/data_bus_controller_bus_timeout_counter.sv
// rtl/data_bus_controller_bus_timeout_counter.sv - saturating watchdog counter for bus transactions
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam int unsigned LAST = (LIMIT > 0) ? LIMIT - 1 : 0;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A limit of zero disables the watchdog entirely.
    assign expired_o = (LIMIT != 0) && (count_q == W'(LAST));

endmodule

// File: rtl/data_bus_controller.sv
// rtl/data_bus_controller.sv - MEM-stage load/store engine driving a variable-latency data bus
module data_bus_controller
    import data_bus_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ERROR_DATA     = DEFAULT_ERROR_DATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            cpu_mem_op,
    input  logic [15:0]           cpu_address,
    input  logic [15:0]           cpu_write_data,
    output logic [15:0]           cpu_read_data,
    output logic                  cpu_stall,
    data_bus_controller_if.master bus,
    output logic                  bus_error,
    input  logic                  error_clear
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        stall;
    logic        timer_clear;
    logic        timer_en;
    logic        timer_expired;

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        stall       = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        // A timeout below overrides a clear in the same cycle.
        if (error_clear) begin
            error_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (is_mem_access(cpu_mem_op)) begin
                    stall       = 1'b1;
                    addr_d      = cpu_address;
                    wdata_d     = cpu_write_data;
                    we_d        = (cpu_mem_op == MEM_OP_STORE);
                    req_d       = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata;
                    end
                end else if (timer_expired) begin
                    req_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = ERROR_DATA;
                    end
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE: begin
                // Pipeline advances this cycle; the still-visible op must not restart.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign cpu_stall      = stall & ~reset;
    assign cpu_read_data  = rdata_q;
    assign bus_error      = error_q;
    assign bus.bus_req    = req_q;
    assign bus.bus_we     = we_q;
    assign bus.bus_addr   = addr_q;
    assign bus.bus_wdata  = wdata_q;

endmodule

// File: tb/tb_data_bus_controller.sv
// tb/tb_data_bus_controller.sv - randomized scoreboard bench for data_bus_controller
module tb_data_bus_controller;
    import data_bus_controller_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cpu_mem_op;
    logic [15:0] cpu_address;
    logic [15:0] cpu_write_data;
    logic [15:0] cpu_read_data;
    logic        cpu_stall;
    logic        bus_error;
    logic        error_clear;

    data_bus_controller_if bus ();

    data_bus_controller #(
        .TIMEOUT_CYCLES (T),
        .ERROR_DATA     (16'hFFFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_mem_op     (cpu_mem_op),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_stall      (cpu_stall),
        .bus            (bus),
        .bus_error      (bus_error),
        .error_clear    (error_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          stall_cyc;
        int          req_cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] rd_model;
    logic        err_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One load/store issued from IDLE; returns one cycle after DONE, back in IDLE.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                           input int dly, input logic [15:0] rd, input bit clr_on_to);
        exp_t e;
        bit   to;
        to          = (dly >= T);
        e.we        = (op == MEM_OP_STORE);
        e.addr      = a;
        e.wdata     = d;
        if (op == MEM_OP_LOAD) rd_model = to ? 16'hFFFF : rd;
        if (to) err_model = 1'b1;
        e.rdata     = rd_model;
        e.err       = err_model;
        e.stall_cyc = to ? T + 1 : dly + 2;
        e.req_cyc   = to ? T : dly + 1;
        sb.push_back(e);

        cpu_mem_op     = op;
        cpu_address    = a;
        cpu_write_data = d;
        @(posedge clk); #1;
        if (!to) begin
            repeat (dly) begin @(posedge clk); #1; end
            bus.bus_ack   = 1'b1;
            bus.bus_rdata = rd;
            @(posedge clk); #1;
            bus.bus_ack   = 1'b0;
            bus.bus_rdata = 16'($urandom);
        end else begin
            repeat (T - 1) begin @(posedge clk); #1; end
            error_clear = clr_on_to;
            @(posedge clk); #1;
            error_clear = 1'b0;
        end
        bus.bus_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        cpu_mem_op  = MEM_OP_NONE;
    endtask

    task automatic gap(input int n, input bit force_clr);
        for (int i = 0; i < n; i++) begin
            cpu_mem_op    = ($urandom_range(0, 1) == 0) ? MEM_OP_NONE : MEM_OP_RSVD;
            bus.bus_ack   = 1'($urandom_range(0, 1));
            bus.bus_rdata = 16'($urandom);
            error_clear   = (force_clr && i == 0) || ($urandom_range(0, 2) == 0);
            if (error_clear) err_model = 1'b0;
            @(posedge clk); #1;
            bus.bus_ack = 1'b0;
            error_clear = 1'b0;
            cpu_mem_op  = MEM_OP_NONE;
        end
    endtask

    logic        prev_stall = 1'b0;
    int          sc = 0, rc = 0;
    bit          have = 0, unstable = 0, after_done = 0;
    logic        cap_we;
    logic [15:0] cap_addr, cap_wdata;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0; sc = 0; rc = 0; have = 0; unstable = 0; after_done = 0;
            end else begin
                if (after_done) begin
                    check("no_req_after_done", bus.bus_req, 1'b0);
                    after_done = 0;
                end
                if (cpu_stall) sc++;
                if (bus.bus_req) begin
                    rc++;
                    if (!have) begin
                        cap_we = bus.bus_we; cap_addr = bus.bus_addr; cap_wdata = bus.bus_wdata; have = 1;
                    end else if (cap_we !== bus.bus_we || cap_addr !== bus.bus_addr ||
                                 cap_wdata !== bus.bus_wdata) begin
                        unstable = 1;
                    end
                end
                if (prev_stall && !cpu_stall) begin
                    if (sb.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("read_data", cpu_read_data, e.rdata);
                        check("bus_error", bus_error, e.err);
                        check("bus_we", cap_we, e.we);
                        check("bus_addr", cap_addr, e.addr);
                        check("bus_wdata", cap_wdata, e.wdata);
                        check("stall_cycles", sc, e.stall_cyc);
                        check("req_cycles", rc, e.req_cyc);
                        check("req_low_in_done", bus.bus_req, 1'b0);
                        check("bus_stable", unstable, 0);
                    end
                    sc = 0; rc = 0; have = 0; unstable = 0; after_done = 1;
                end
                prev_stall = cpu_stall;
            end
        end
    end

    initial begin
        logic [1:0] op;
        int         dly;
        reset          = 1'b1;
        cpu_mem_op     = MEM_OP_LOAD;
        cpu_address    = 16'h1111;
        cpu_write_data = 16'h2222;
        error_clear    = 1'b0;
        bus.bus_ack    = 1'b0;
        bus.bus_rdata  = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", bus.bus_req, 1'b0);
        check("rst_bus_we", bus.bus_we, 1'b0);
        check("rst_bus_addr", bus.bus_addr, 16'h0);
        check("rst_bus_wdata", bus.bus_wdata, 16'h0);
        check("rst_read_data", cpu_read_data, 16'h0);
        check("rst_bus_error", bus_error, 1'b0);
        check("rst_stall", cpu_stall, 1'b0);
        cpu_mem_op = MEM_OP_NONE;
        @(posedge clk); #1;
        reset     = 1'b0;
        rd_model  = 16'h0;
        err_model = 1'b0;
        @(posedge clk); #1;

        run_txn(MEM_OP_LOAD, 16'h0010, 16'($urandom), 3, 16'hBEEF, 0);
        gap(1, 0);
        run_txn(MEM_OP_STORE, 16'h0020, 16'h1234, 0, 16'h7777, 0);
        gap(2, 0);
        run_txn(MEM_OP_LOAD, 16'h0030, 16'($urandom), T, 16'h0, 0);
        run_txn(MEM_OP_STORE, 16'h0040, 16'h4444, 1, 16'h0, 0);
        gap(1, 1);
        run_txn(MEM_OP_LOAD, 16'h0050, 16'($urandom), T - 1, 16'h00A5, 0);
        run_txn(MEM_OP_STORE, 16'h0060, 16'hCAFE, 1, 16'h0, 0);
        run_txn(MEM_OP_LOAD, 16'h0060, 16'($urandom), 2, 16'hD00D, 0);
        run_txn(MEM_OP_LOAD, 16'h0070, 16'($urandom), T, 16'h0, 1);

        for (int n = 0; n < 40; n++) begin
            op  = ($urandom_range(0, 1) == 0) ? MEM_OP_LOAD : MEM_OP_STORE;
            dly = $urandom_range(0, T + 1);
            run_txn(op, 16'($urandom), 16'($urandom), dly, 16'($urandom), 1'($urandom_range(0, 1)));
            gap($urandom_range(0, 2), 0);
        end

        cpu_mem_op  = MEM_OP_LOAD;
        cpu_address = 16'h0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("wait_rst_bus_req", bus.bus_req, 1'b0);
        check("wait_rst_stall", cpu_stall, 1'b0);
        check("wait_rst_bus_error", bus_error, 1'b0);
        check("wait_rst_read_data", cpu_read_data, 16'h0);
        @(posedge clk); #1;
        cpu_mem_op = MEM_OP_NONE;
        reset      = 1'b0;
        rd_model   = 16'h0;
        err_model  = 1'b0;
        @(posedge clk); #1;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 16'h1234;
        @(posedge clk); #1;
        bus.bus_ack = 1'b0;
        check("late_ack_ignored_data", cpu_read_data, 16'h0);
        check("late_ack_ignored_req", bus.bus_req, 1'b0);
        run_txn(MEM_OP_LOAD, 16'h0090, 16'h0, 2, 16'h5A5A, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
